// File: rtl/apb_arb_pkg.sv
// Shared types for the APB round-robin master: FSM state encoding and the latched command.
package apb_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    // Command latch is sized for the widest supported bus; the top slices out AW/DW.
    localparam int AW_MAX = 64;
    localparam int DW_MAX = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic              write;
        logic [AW_MAX-1:0] addr;
        logic [DW_MAX-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_arb_master_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched from an internal pointer,
// pointer moves past the winner only when the grant is consumed.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            ptr_rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    always_comb begin
        int            c;
        logic [IW-1:0] ci;
        c         = 0;
        ci        = '0;
        w_found   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(r_ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            ci = IW'(c);
            if (!w_found && req[ci]) begin
                w_found   = 1'b1;
                grant_idx = ci;
            end
        end
        grant_onehot = w_found ? (NREQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (ptr_rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NREQ requesters: round-robin accept, SETUP/ACCESS sequencing with
// PREADY wait states, one-cycle response pulse back to the issuing requester.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AW-1:0]     PADDR,
    output logic [DW-1:0]     PWDATA,
    input  logic [DW-1:0]     PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int IW = $clog2(NREQ);

    apb_state_t      r_state;
    apb_cmd_t        r_cmd;
    logic [IW-1:0]   r_owner;
    logic            r_psel;
    logic            r_penable;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gidx;
    logic            w_accept;
    apb_cmd_t        w_cmd;
    logic [AW-1:0]   w_addr_arr  [NREQ];
    logic [DW-1:0]   w_wdata_arr [NREQ];
    logic            w_unused_cmd;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*AW +: AW];
        assign w_wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // A new command is taken from IDLE, or in the PREADY cycle of ACCESS to keep PSEL1 high.
    assign w_accept  = !PRESET && (|req_valid) &&
                       ((r_state == IDLE) || ((r_state == ACCESS) && PREADY));
    assign req_ready = w_accept ? w_grant : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk          (clk),
        .ptr_rst      (PRESET),
        .req          (req_valid),
        .advance      (w_accept),
        .grant_onehot (w_grant),
        .grant_idx    (w_gidx)
    );

    always_comb begin
        w_cmd       = '0;
        w_cmd.write = req_write[w_gidx];
        w_cmd.addr  = AW_MAX'(w_addr_arr[w_gidx]);
        w_cmd.wdata = DW_MAX'(w_wdata_arr[w_gidx]);
    end

    always_ff @(posedge clk) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_owner     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= w_cmd;
                        r_owner <= w_gidx;
                        r_psel  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NREQ'(1) << r_owner;
                        r_rsp_rdata <= r_cmd.write ? '0 : PRDATA;
                        r_rsp_err   <= PSLVERR;
                        if (w_accept) begin
                            r_cmd   <= w_cmd;
                            r_owner <= w_gidx;
                            r_state <= SETUP;
                        end else begin
                            r_psel  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign PSEL1     = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_cmd.write;
    assign PADDR     = r_cmd.addr[AW-1:0];
    assign PWDATA    = r_cmd.wdata[DW-1:0];
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Latch bits above AW/DW are constant zero.
    assign w_unused_cmd = ^{r_cmd.addr, r_cmd.wdata};

    enable_ch: assert property (@(posedge clk) disable iff (PRESET)
        PENABLE |-> (PSEL1 && $past(PSEL1)))
        else $error("enable_ch violated");

    stable_ch: assert property (@(posedge clk) disable iff (PRESET)
        (PSEL1 && (!PENABLE || !PREADY)) |=>
        (PENABLE && $stable(PADDR) && $stable(PWRITE) && $stable(PWDATA)))
        else $error("stable_ch violated");

    enable_deassert_ch: assert property (@(posedge clk) disable iff (PRESET)
        (PENABLE && PREADY) |=> !PENABLE)
        else $error("enable_deassert_ch violated");

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: reset, single write, wait states, round-robin contention,
// slave error, and reset in the middle of a transfer.
module tb_apb_arb_master;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              PRESET = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL1;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA = '0;
    logic              PREADY = 1'b1;
    logic              PSLVERR = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_arb_master #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]          = 1'b1;
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Runs a fixed number of cycles, dropping each requester's valid after its acceptance edge,
    // logging (index+1) and (cycle+1) per grant/response as nibbles.
    task automatic run_burst(input int cycles, output logic [31:0] glog, output logic [31:0] tlog,
                             output logic [31:0] rlog, output logic [31:0] rtlog, output int psel_cnt);
        logic [NREQ-1:0] prev = '0;
        glog = '0; tlog = '0; rlog = '0; rtlog = '0; psel_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            if (req_ready != '0) begin
                glog = (glog << 4) | 32'(oh2i(req_ready) + 1);
                tlog = (tlog << 4) | 32'(c + 1);
            end
            if (rsp_valid != '0) begin
                rlog  = (rlog << 4) | 32'(oh2i(rsp_valid) + 1);
                rtlog = (rtlog << 4) | 32'(c + 1);
            end
            if (PSEL1) psel_cnt++;
            prev = req_ready;
            tick();
            req_valid = req_valid & ~prev;
            #1;
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) tick();
        checks++;
        if ({PSEL1, PENABLE, PWRITE, rsp_err, rsp_valid, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {PSEL1, PENABLE, PWRITE, rsp_err, rsp_valid, req_ready});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {PADDR, PWDATA, rsp_rdata});
        end
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PSEL1 !== 1'b0) begin
                failures++;
                $display("FAIL idle_psel cyc=%0d got=%b exp=0", i, PSEL1);
            end
        end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        PREADY = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL wr_accept got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({PSEL1, PENABLE} !== 2'b10) begin
            failures++; $display("FAIL wr_setup got=%b exp=10", {PSEL1, PENABLE});
        end
        checks++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin
            failures++; $display("FAIL wr_bus got=%h exp=%h", {PWRITE, PADDR, PWDATA}, {1'b1, 32'h10, 32'hDEADBEEF});
        end
        tick();
        checks++;
        if ({PSEL1, PENABLE} !== 2'b11) begin
            failures++; $display("FAIL wr_access got=%b exp=11", {PSEL1, PENABLE});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h0}) begin
            failures++; $display("FAIL wr_rsp got=%b/%b/%h exp=0001/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({PSEL1, PENABLE} !== 2'b00) begin
            failures++; $display("FAIL wr_release got=%b exp=00", {PSEL1, PENABLE});
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL wr_pulse got=%b exp=0000", rsp_valid);
        end
    endtask

    task automatic test_wait_states();
        set_req(1, 1'b0, 32'h20, 32'h0);
        PREADY = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL ws_accept got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({PSEL1, PENABLE} !== 2'b10) begin
            failures++; $display("FAIL ws_setup got=%b exp=10", {PSEL1, PENABLE});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({PSEL1, PENABLE, PWRITE, PADDR} !== {3'b110, 32'h20}) begin
                failures++; $display("FAIL ws_hold cyc=%0d got=%h exp=%h", i, {PSEL1, PENABLE, PWRITE, PADDR}, {3'b110, 32'h20});
            end
            checks++;
            if (rsp_valid !== 4'b0000) begin
                failures++; $display("FAIL ws_early_rsp cyc=%0d got=%b exp=0000", i, rsp_valid);
            end
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'h1234;
            end
            tick();
        end
        checks++;
        if (rsp_valid !== 4'b0010) begin
            failures++; $display("FAIL ws_rsp got=%b exp=0010", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'h1234) begin
            failures++; $display("FAIL ws_rdata got=%h exp=00001234", rsp_rdata);
        end
        checks++;
        if (PENABLE !== 1'b0) begin
            failures++; $display("FAIL ws_penable_fall got=%b exp=0", PENABLE);
        end
        PRDATA = '0;
    endtask

    task automatic test_contention();
        logic [31:0] glog, tlog, rlog, rtlog;
        int          pc;
        PRESET = 1'b1;
        repeat (2) tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
        #1;
        run_burst(12, glog, tlog, rlog, rtlog, pc);
        checks++;
        if (glog !== 32'h1234) begin
            failures++; $display("FAIL rr_order4 got=%h exp=1234", glog);
        end
        checks++;
        if (tlog !== 32'h1357) begin
            failures++; $display("FAIL rr_grant_cycles4 got=%h exp=1357", tlog);
        end
        checks++;
        if ({rlog, rtlog} !== {32'h1234, 32'h468A}) begin
            failures++; $display("FAIL rr_rsp4 got=%h/%h exp=1234/468a", rlog, rtlog);
        end
        checks++;
        if (pc !== 8) begin
            failures++; $display("FAIL rr_psel_hold4 got=%0d exp=8", pc);
        end
        set_req(0, 1'b0, 32'h200, 32'h0);
        set_req(2, 1'b0, 32'h208, 32'h0);
        #1;
        run_burst(8, glog, tlog, rlog, rtlog, pc);
        checks++;
        if ({glog, tlog} !== {32'h13, 32'h13}) begin
            failures++; $display("FAIL rr_order2 got=%h/%h exp=13/13", glog, tlog);
        end
        checks++;
        if ({rlog, rtlog} !== {32'h13, 32'h46}) begin
            failures++; $display("FAIL rr_rsp2 got=%h/%h exp=13/46", rlog, rtlog);
        end
        checks++;
        if (pc !== 4) begin
            failures++; $display("FAIL rr_psel_hold2 got=%0d exp=4", pc);
        end
    endtask

    task automatic test_error();
        set_req(3, 1'b0, 32'h30, 32'h0);
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hBAD00001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL err_accept got=%b exp=1000", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 1'b1, 32'hBAD00001}) begin
            failures++; $display("FAIL err_rsp got=%b/%b/%h exp=1000/1/bad00001", rsp_valid, rsp_err, rsp_rdata);
        end
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFFFFFF;
        tick();
        set_req(2, 1'b1, 32'h40, 32'h5555AAAA);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL wr2_accept got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h40, 32'h5555AAAA}) begin
            failures++; $display("FAIL wr2_bus got=%h exp=%h", {PWRITE, PADDR, PWDATA}, {1'b1, 32'h40, 32'h5555AAAA});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, 1'b0, 32'h0}) begin
            failures++; $display("FAIL wr2_rsp got=%b/%b/%h exp=0100/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        PRDATA = '0;
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b0, 32'h50, 32'h0);
        PREADY = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL mid_accept got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if ({PSEL1, PENABLE} !== 2'b11) begin
            failures++; $display("FAIL mid_access got=%b exp=11", {PSEL1, PENABLE});
        end
        PRESET = 1'b1;
        tick();
        checks++;
        if ({PSEL1, PENABLE, rsp_valid} !== '0) begin
            failures++; $display("FAIL mid_abort got=%b exp=0", {PSEL1, PENABLE, rsp_valid});
        end
        PRESET = 1'b0;
        PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({PSEL1, rsp_valid} !== '0) begin
                failures++; $display("FAIL mid_no_rsp cyc=%0d got=%b exp=0", i, {PSEL1, rsp_valid});
            end
        end
        // Pointer was reset, so requester 0 must beat requester 3.
        set_req(0, 1'b1, 32'h60, 32'h0BADF00D);
        set_req(3, 1'b0, 32'h64, 32'h0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL post_accept0 got=%b exp=0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL post_accept3 got=%b exp=1000", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h0}) begin
            failures++; $display("FAIL post_rsp0 got=%b/%b/%h exp=0001/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({PSEL1, PENABLE, PADDR} !== {2'b10, 32'h64}) begin
            failures++; $display("FAIL post_setup3 got=%h exp=%h", {PSEL1, PENABLE, PADDR}, {2'b10, 32'h64});
        end
        repeat (2) tick();
        checks++;
        if (rsp_valid !== 4'b1000) begin
            failures++; $display("FAIL post_rsp3 got=%b exp=1000", rsp_valid);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_wait_states();
        test_contention();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
